// File: rtl/cache_pkg.sv
// cache_pkg: shared line/word geometry and adapter state encoding for the cache subsystem
package cache_pkg;
  localparam int WORD_W      = 32;
  localparam int LINE_WORDS  = 8;
  localparam int LINE_W      = 256;
  localparam int ACK_TIMEOUT = 63;
  typedef enum logic [1:0] {IDLE, WB_BEAT, FILL_BEAT, RESP} ca_state_t;
endpackage

// File: rtl/cache_line_adapter.sv
// cache_line_adapter: bursts 256-bit cache lines to/from a 32-bit word memory; ports: clk, rst (async high), mem_read/mem_write/line_addr/wb_line in, fill_line/ca_resp/busy/error out, mm_addr/mm_re/mm_we/mm_wdata out, mm_rdata/mm_ack in
module cache_line_adapter
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [26:0]         line_addr,
  input  logic [LINE_W-1:0]   wb_line,
  output logic [LINE_W-1:0]   fill_line,
  output logic                ca_resp,
  output logic                busy,
  output logic                error,
  output logic [31:0]         mm_addr,
  output logic                mm_re,
  output logic                mm_we,
  output logic [WORD_W-1:0]   mm_wdata,
  input  logic [WORD_W-1:0]   mm_rdata,
  input  logic                mm_ack
);
  ca_state_t state, state_n;
  logic [26:0] addr_q;
  logic [LINE_W-1:0] wb_q;
  logic [2:0] beat;
  logic [5:0] wdog;
  logic in_beat, ack, timeout;
  assign in_beat = state == WB_BEAT || state == FILL_BEAT;
  assign ack     = in_beat && mm_ack;
  // an ack arriving in the last watchdog cycle still completes the beat
  assign timeout = in_beat && !mm_ack && wdog == 6'(ACK_TIMEOUT);
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (mem_write ? WB_BEAT : mem_read ? FILL_BEAT : IDLE)
            : state == RESP ? IDLE
            : (timeout || (ack && beat == 3'd7)) ? RESP : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      wb_q      <= '0;
      beat      <= '0;
      wdog      <= '0;
      fill_line <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        if (mem_write) wb_q <= wb_line;
        if (mem_write || mem_read) addr_q <= line_addr;
        beat <= '0;
        wdog <= '0;
      end else if (ack) begin
        if (state == FILL_BEAT) fill_line[{beat, 5'b0} +: WORD_W] <= mm_rdata;
        beat <= beat + 3'd1;
        wdog <= '0;
      end else if (in_beat) begin
        wdog <= wdog + 6'd1;
      end
    end
  end
  assign mm_re    = state == FILL_BEAT;
  assign mm_we    = state == WB_BEAT;
  assign mm_addr  = in_beat ? {addr_q, beat, 2'b00} : '0;
  assign mm_wdata = mm_we ? wb_q[{beat, 5'b0} +: WORD_W] : '0;
  assign ca_resp  = state == RESP;
  assign busy     = state != IDLE;
  assign error    = timeout;
endmodule

// File: tb/tb_cache_line_adapter.sv
// tb_cache_line_adapter: directed self-checking bench for cache_line_adapter
module tb_cache_line_adapter;
  logic         clk = 0;
  logic         rst;
  logic         mem_read, mem_write;
  logic [26:0]  line_addr;
  logic [255:0] wb_line, fill_line;
  logic         ca_resp, busy, error;
  logic [31:0]  mm_addr, mm_wdata, mm_rdata;
  logic         mm_re, mm_we, mm_ack;
  int errors = 0;
  int checks = 0;
  cache_line_adapter dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .line_addr(line_addr), .wb_line(wb_line), .fill_line(fill_line),
    .ca_resp(ca_resp), .busy(busy), .error(error), .mm_addr(mm_addr),
    .mm_re(mm_re), .mm_we(mm_we), .mm_wdata(mm_wdata), .mm_rdata(mm_rdata),
    .mm_ack(mm_ack)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic fill(input logic [26:0] a, input logic [31:0] base);
    logic [255:0] exp;
    exp = '0;
    for (int i = 0; i < 8; i++) exp[32*i +: 32] = base + 32'(i);
    line_addr = a;
    mem_read = 1;
    mm_ack = 1;
    tick;
    mem_read = 0;
    for (int k = 0; k < 8; k++) begin
      mm_rdata = base + 32'(k);
      chk("fill_re", mm_re, 1);
      chk("fill_we", mm_we, 0);
      chk("fill_addr", mm_addr, {a, 5'b0} + 32'(4 * k));
      chk("fill_busy", busy, 1);
      chk("fill_resp_early", ca_resp, 0);
      tick;
    end
    mm_ack = 0;
    chk("fill_resp", ca_resp, 1);
    chk("fill_line", fill_line, exp);
    chk("fill_resp_busy", busy, 1);
    tick;
    chk("fill_resp_end", ca_resp, 0);
    chk("fill_idle", busy, 0);
  endtask
  initial begin
    logic [255:0] wl;
    int cnt;
    int n;
    rst = 1; mem_read = 0; mem_write = 0; line_addr = '0; wb_line = '0;
    mm_rdata = '0; mm_ack = 0;
    #2;
    chk("rst_fill_line", fill_line, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {mm_re, mm_we, ca_resp, error}, 0);
    chk("rst_addr", mm_addr, 0);
    chk("rst_wdata", mm_wdata, 0);
    tick;
    rst = 0;
    tick;
    fill(27'h123_4567, 32'h1000);
    for (int i = 0; i < 8; i++) wl[32*i +: 32] = 32'hA0 + 32'(i);
    wb_line = wl;
    line_addr = 27'h0AB_CDEF;
    mem_write = 1;
    tick;
    mem_write = 0;
    wb_line = '0;
    for (int k = 0; k < 8; k++) begin
      for (int w = 0; w < 3; w++) begin
        mm_ack = (w == 2);
        chk("wb_we", mm_we, 1);
        chk("wb_re", mm_re, 0);
        chk("wb_wdata", mm_wdata, 32'hA0 + 32'(k));
        chk("wb_addr", mm_addr, {27'h0AB_CDEF, 5'b0} + 32'(4 * k));
        tick;
      end
    end
    mm_ack = 0;
    chk("wb_resp", ca_resp, 1);
    chk("wb_we_off", mm_we, 0);
    tick;
    chk("wb_idle", busy, 0);
    wb_line = wl;
    line_addr = 27'h000_0040;
    mem_write = 1;
    mem_read = 1;
    mm_ack = 1;
    tick;
    mem_write = 0;
    mem_read = 0;
    for (int k = 0; k < 8; k++) begin
      chk("both_we", mm_we, 1);
      chk("both_re", mm_re, 0);
      tick;
    end
    mm_ack = 0;
    chk("both_resp", ca_resp, 1);
    chk("both_re_end", mm_re, 0);
    tick;
    chk("both_idle", busy, 0);
    line_addr = 27'h000_0100;
    mem_read = 1;
    mm_ack = 1;
    tick;
    mem_read = 0;
    tick; tick; tick;
    mem_read = 1;
    tick;
    mem_read = 0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cnt += int'(ca_resp);
      tick;
    end
    mm_ack = 0;
    chk("busy_req_resp_count", cnt, 1);
    chk("busy_req_idle", busy, 0);
    line_addr = 27'h000_0200;
    mem_read = 1;
    mm_ack = 1;
    tick;
    mem_read = 0;
    for (int k = 0; k < 4; k++) begin
      mm_rdata = 32'h2000 + 32'(k);
      tick;
    end
    chk("rst_mid_addr_pre", mm_addr, {27'h000_0200, 5'b0} + 32'd16);
    rst = 1;
    #1;
    chk("rst_mid_fill_line", fill_line, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_strobes", {mm_re, mm_we, ca_resp, error}, 0);
    chk("rst_mid_addr", mm_addr, 0);
    mm_ack = 0;
    tick;
    rst = 0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cnt += int'(ca_resp) + int'(mm_re) + int'(mm_we);
      tick;
    end
    chk("rst_mid_no_activity", cnt, 0);
    fill(27'h7FF_FFFF, 32'h3000);
    line_addr = 27'h000_0300;
    mem_read = 1;
    mm_ack = 1;
    tick;
    mem_read = 0;
    tick; tick;
    mm_ack = 0;
    chk("to_addr_beat2", mm_addr, {27'h000_0300, 5'b0} + 32'd8);
    n = 0;
    while (!error && n < 100) begin
      chk("to_no_resp", ca_resp, 0);
      tick;
      n++;
    end
    chk("to_cycles", n, 63);
    chk("to_error", error, 1);
    chk("to_still_re", mm_re, 1);
    tick;
    chk("to_resp", ca_resp, 1);
    chk("to_error_pulse", error, 0);
    chk("to_re_off", mm_re, 0);
    tick;
    chk("to_idle", busy, 0);
    chk("to_resp_end", ca_resp, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cache_line_adapter.md
CACHE_LINE_ADAPTER -- requirements
Module: cache_line_adapter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port mem_read, input, 1 bit: line-fill request pulse from the cache controller.
REQ-004 SHALL have port mem_write, input, 1 bit: line write-back request pulse from the cache controller.
REQ-005 SHALL have port line_addr, input, 27 bits: line address, byte address [31:5].
REQ-006 SHALL have port wb_line, input, 256 bits: write-back line; word i occupies [32i+31:32i].
REQ-007 SHALL have port fill_line, output, 256 bits: fetched line, same word layout as wb_line.
REQ-008 SHALL have port ca_resp, output, 1 bit: one-cycle transfer-complete pulse to the cache controller.
REQ-009 SHALL have port busy, output, 1 bit: high while a transfer is in progress.
REQ-010 SHALL have port error, output, 1 bit: one-cycle pulse on beat timeout.
REQ-011 SHALL have port mm_addr, output, 32 bits: main-memory word byte address.
REQ-012 SHALL have ports mm_re and mm_we, outputs, 1 bit each: word read and word write strobes.
REQ-013 SHALL have port mm_wdata, output, 32 bits: write word.
REQ-014 SHALL have port mm_rdata, input, 32 bits: read word, valid when mm_ack is high.
REQ-015 SHALL have port mm_ack, input, 1 bit: per-beat acknowledge from main memory.

Function
REQ-016 SHALL implement states IDLE, WB_BEAT, FILL_BEAT, RESP.
REQ-017 In IDLE, a high mem_write SHALL latch line_addr and wb_line, clear the beat counter, and go to WB_BEAT; otherwise a high mem_read SHALL latch line_addr and go to FILL_BEAT.
REQ-018 When mem_write and mem_read are both high in IDLE, mem_write SHALL win and mem_read SHALL be dropped.
REQ-019 Requests arriving outside IDLE SHALL be ignored, with no queueing.
REQ-020 In WB_BEAT and FILL_BEAT, the block SHALL drive mm_addr = {addr_q, beat, 2'b00}; it SHALL hold mm_we (respectively mm_re) high with mm_wdata = word[beat] until it samples mm_ack high.
REQ-021 On an mm_ack in FILL_BEAT, mm_rdata SHALL be written into fill_line word[beat]; fill_line SHALL hold its value at all other times.
REQ-022 The 3-bit beat counter SHALL increment on each ack; an ack at beat 7 SHALL wrap the counter to 0 and go to RESP.
REQ-023 mm_ack SHALL be ignored outside the beat states.
REQ-024 RESP SHALL assert ca_resp for exactly one cycle and then return to IDLE.
REQ-025 busy SHALL be high in WB_BEAT, FILL_BEAT and RESP.
REQ-026 Minimum latency, with mm_ack held high: request accepted at edge 0; 8 beats on edges 1 to 8; ca_resp high during cycle 9; a new request is accepted at edge 10.
REQ-027 A 6-bit watchdog SHALL count cycles without ack within a beat and SHALL clear on each ack.
REQ-028 When the watchdog reaches 63, the block SHALL pulse error, abort the burst, and go to RESP so that ca_resp still fires.
REQ-029 The strobes mm_re and mm_we SHALL never be high simultaneously.

Reset
REQ-030 While rst is high, the block SHALL set state to IDLE and clear the counter and watchdog, and SHALL drive fill_line, ca_resp, busy, error, mm_re, mm_we, mm_addr and mm_wdata to 0.
REQ-031 A reset asserted mid-burst SHALL abort the burst immediately, with no ca_resp and no further strobes.

Structure
REQ-032 Package cache_pkg SHALL hold WORD_W=32, LINE_WORDS=8, LINE_W=256, ACK_TIMEOUT=63 and the adapter state enum; the cache controller shares the same package.
REQ-033 The block SHALL be a single module with no sub-modules.

Verification
REQ-034 Bench SHALL cover a fill with mm_ack tied high and mm_rdata = 0x1000+beat: required response is fill_line words 0x1000 to 0x1007, mm_addr stepping by 4 from {line_addr,5'b0}, and ca_resp at cycle 9.
REQ-035 Bench SHALL cover a write-back with wb_line word i = 0xA0+i and ack delayed 2 cycles per beat: required response is mm_wdata 0xA0 to 0xA7, mm_we held through each wait, and ca_resp after the last ack.
REQ-036 Bench SHALL cover simultaneous mem_read and mem_write: required response is a write burst only, with mm_re never asserted.
REQ-037 Bench SHALL cover mem_read pulsed while busy: the request is ignored, and exactly one ca_resp occurs.
REQ-038 Bench SHALL cover rst asserted at beat 4 of a fill: outputs are 0 at once, no ca_resp, and a next fill completes normally.
REQ-039 Bench SHALL cover mm_ack held low at beat 2: required response is an error pulse after 63 cycles, then ca_resp, then busy low.
